// File: rtl/sr_seq_pkg.sv
// rtl/sr_seq_pkg.sv - shared encodings and helpers for the SR latch pulse sequencer
package sr_seq_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SETUP = 2'b01,
        ST_PULSE = 2'b10,
        ST_HOLD  = 2'b11
    } state_t;

    // Returns {set, reset}; never both high. Toggle from an unknown state falls back to reset.
    function automatic logic [1:0] resolve_op(input op_t op, input logic exp_valid, input logic exp_q);
        logic [1:0] sr;
        case (op)
            OP_SET:   sr = 2'b10;
            OP_RESET: sr = 2'b01;
            OP_HOLD:  sr = 2'b00;
            default:  sr = (exp_valid && !exp_q) ? 2'b10 : 2'b01;
        endcase
        return sr;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous latch feedback
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture so the second flop sees a settled value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sr_latch_pulse_sequencer.sv
// rtl/sr_latch_pulse_sequencer.sv - timed set/reset/enable driver with latch readback check
module sr_latch_pulse_sequencer
    import sr_seq_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       latch_enable,
    output logic       latch_set,
    output logic       latch_reset,
    input  logic       latch_q,
    input  logic       latch_q_,
    output logic       expected_q,
    output logic       expected_valid,
    output logic       done,
    output logic       mismatch,
    output logic [7:0] cmd_count
);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             q_sync;
    logic             qn_sync;
    logic [1:0]       sr_next;
    logic             upd_q;
    logic             upd_valid;
    logic             check_fail;

    sync_2ff u_sync_q (
        .clock (clock),
        .reset (reset),
        .d     (latch_q),
        .q     (q_sync)
    );

    sync_2ff u_sync_qn (
        .clock (clock),
        .reset (reset),
        .d     (latch_q_),
        .q     (qn_sync)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign sr_next   = resolve_op(op_t'(cmd_op), expected_valid, expected_q);

    // Expected latch state after the in-flight command completes; the held S/R encode the resolved op.
    always_comb begin
        upd_q     = expected_q;
        upd_valid = expected_valid;
        if (latch_set) begin
            upd_q     = 1'b1;
            upd_valid = 1'b1;
        end else if (latch_reset) begin
            upd_q     = 1'b0;
            upd_valid = 1'b1;
        end
    end

    // Readback is wrong if the rails are not complementary or disagree with a known expected state.
    always_comb begin
        check_fail = (qn_sync != ~q_sync) || (upd_valid && (q_sync != upd_q));
    end

    // Phase sequencer: data setup, enable pulse, data hold; all latch drives registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            latch_enable   <= 1'b0;
            latch_set      <= 1'b0;
            latch_reset    <= 1'b0;
            expected_q     <= 1'b0;
            expected_valid <= 1'b0;
            done           <= 1'b0;
            mismatch       <= 1'b0;
            cmd_count      <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        latch_set   <= sr_next[1];
                        latch_reset <= sr_next[0];
                        cnt         <= SETUP_LOAD;
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        latch_enable <= 1'b1;
                        cnt          <= PULSE_LOAD;
                        state        <= ST_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        latch_enable <= 1'b0;
                        cnt          <= HOLD_LOAD;
                        state        <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        latch_set      <= 1'b0;
                        latch_reset    <= 1'b0;
                        expected_q     <= upd_q;
                        expected_valid <= upd_valid;
                        done           <= 1'b1;
                        cmd_count      <= cmd_count + 8'd1;
                        if (check_fail) begin
                            mismatch <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_pulse_sequencer.sv
// tb/tb_sr_latch_pulse_sequencer.sv - self-checking bench with latch model and reference model
module tb_sr_latch_pulse_sequencer;

    localparam int S_CYC = 2;
    localparam int P_CYC = 4;
    localparam int H_CYC = 2;
    localparam int TOTAL = S_CYC + P_CYC + H_CYC;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_ready;
    logic       latch_enable;
    logic       latch_set;
    logic       latch_reset;
    logic       latch_q;
    logic       latch_q_;
    logic       expected_q;
    logic       expected_valid;
    logic       done;
    logic       mismatch;
    logic [7:0] cmd_count;

    logic lat_q = 1'b0;
    logic preset_req = 1'b0;
    logic preset_val = 1'b0;
    logic stuck0 = 1'b0;

    int checks = 0;
    int errors = 0;

    bit         m_active = 1'b0;
    int         m_k = 0;
    logic       m_s = 1'b0;
    logic       m_r = 1'b0;
    logic       m_en = 1'b0;
    logic       m_done = 1'b0;
    logic       m_eq = 1'b0;
    logic       m_ev = 1'b0;
    logic       m_mis = 1'b0;
    logic [7:0] m_cnt = 8'd0;

    sr_latch_pulse_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_op         (cmd_op),
        .cmd_ready      (cmd_ready),
        .latch_enable   (latch_enable),
        .latch_set      (latch_set),
        .latch_reset    (latch_reset),
        .latch_q        (latch_q),
        .latch_q_       (latch_q_),
        .expected_q     (expected_q),
        .expected_valid (expected_valid),
        .done           (done),
        .mismatch       (mismatch),
        .cmd_count      (cmd_count)
    );

    always #5 clock = ~clock;

    // Gated SR latch model with preset and a stuck-at-0 q fault.
    always @(latch_enable or latch_set or latch_reset or preset_req) begin
        if (preset_req) lat_q = preset_val;
        else if (latch_enable) begin
            if (latch_set && !latch_reset) lat_q = 1'b1;
            else if (latch_reset && !latch_set) lat_q = 1'b0;
        end
    end
    assign latch_q  = stuck0 ? 1'b0 : lat_q;
    assign latch_q_ = ~lat_q;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preset(input logic v);
        preset_val = v;
        preset_req = 1'b1;
        #1;
        preset_req = 1'b0;
    endtask

    task automatic send(input logic [1:0] op);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("ready_timeout", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clock);
        while (!done && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("done_timeout", done, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Reference model: outputs as a function of cycles elapsed since acceptance.
    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_active = 1'b0; m_k = 0; m_s = 1'b0; m_r = 1'b0; m_en = 1'b0;
            m_done = 1'b0; m_eq = 1'b0; m_ev = 1'b0; m_mis = 1'b0; m_cnt = 8'd0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (cmd_valid) begin
                    m_active = 1'b1;
                    m_k = 0;
                    case (cmd_op)
                        2'b10:   {m_s, m_r} = 2'b10;
                        2'b01:   {m_s, m_r} = 2'b01;
                        2'b00:   {m_s, m_r} = 2'b00;
                        default: {m_s, m_r} = (m_ev && !m_eq) ? 2'b10 : 2'b01;
                    endcase
                end
            end else begin
                m_k++;
                if (m_k == TOTAL) begin
                    if (m_s) begin m_eq = 1'b1; m_ev = 1'b1; end
                    else if (m_r) begin m_eq = 1'b0; m_ev = 1'b1; end
                    if ((latch_q_ !== ~latch_q) || (m_ev && (latch_q !== m_eq))) m_mis = 1'b1;
                    m_cnt = m_cnt + 8'd1;
                    m_done = 1'b1;
                    m_active = 1'b0;
                    m_s = 1'b0;
                    m_r = 1'b0;
                end
            end
            m_en = m_active && (m_k >= S_CYC) && (m_k < S_CYC + P_CYC);
        end
    end

    // Compare DUT against the model on every falling edge outside reset.
    initial forever begin
        @(negedge clock);
        chk("s_and_r", latch_set & latch_reset, 0);
        if (!reset) begin
            chk("m_cmd_ready", cmd_ready, !m_active);
            chk("m_latch_enable", latch_enable, m_en);
            chk("m_latch_set", latch_set, m_s);
            chk("m_latch_reset", latch_reset, m_r);
            chk("m_done", done, m_done);
            chk("m_expected_q", expected_q, m_eq);
            chk("m_expected_valid", expected_valid, m_ev);
            chk("m_mismatch", mismatch, m_mis);
            chk("m_cmd_count", cmd_count, m_cnt);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        preset(1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_enable", latch_enable, 0);
        chk("rst_exp_valid", expected_valid, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_count", cmd_count, 0);

        // Set accepted at edge 0: enable over edges 2..6, done at edge 8.
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 2'b10;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        @(negedge clock);
        chk("t1_set_e0", latch_set, 1);
        chk("t1_en_e0", latch_enable, 0);
        chk("t1_busy_e0", cmd_ready, 0);
        @(negedge clock);
        chk("t1_en_e1", latch_enable, 0);
        @(negedge clock);
        chk("t1_en_e2", latch_enable, 1);
        repeat (4) @(negedge clock);
        chk("t1_en_e6", latch_enable, 0);
        chk("t1_set_e6", latch_set, 1);
        @(negedge clock);
        chk("t1_done_e7", done, 0);
        @(negedge clock);
        chk("t1_done_e8", done, 1);
        chk("t1_exp_q", expected_q, 1);
        chk("t1_exp_valid", expected_valid, 1);
        chk("t1_mismatch", mismatch, 0);
        chk("t1_count", cmd_count, 1);
        chk("t1_set_cleared", latch_set, 0);

        // Toggle twice against the latch: resolves to reset, then set.
        send(2'b11);
        @(negedge clock);
        chk("t2_tog1_reset", latch_reset, 1);
        wait_done();
        send(2'b11);
        @(negedge clock);
        chk("t2_tog2_set", latch_set, 1);
        wait_done();
        chk("t2_exp_q", expected_q, 1);
        chk("t2_mismatch", mismatch, 0);
        chk("t2_count", cmd_count, 3);

        // Hold right after reset with the latch holding q=1.
        reset = 1'b1;
        preset(1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        send(2'b00);
        repeat (3) @(negedge clock);
        chk("t3_en", latch_enable, 1);
        chk("t3_s", latch_set, 0);
        chk("t3_r", latch_reset, 0);
        wait_done();
        chk("t3_exp_valid", expected_valid, 0);
        chk("t3_mismatch", mismatch, 0);
        chk("t3_latch_kept", latch_q, 1);

        // Stuck-at-0 q: mismatch rises and is sticky until reset.
        stuck0 = 1'b1;
        send(2'b10);
        wait_done();
        chk("t4_mismatch_set", mismatch, 1);
        stuck0 = 1'b0;
        send(2'b10);
        wait_done();
        send(2'b01);
        wait_done();
        chk("t4_mismatch_sticky", mismatch, 1);
        pulse_reset();
        chk("t4_mismatch_cleared", mismatch, 0);

        // cmd_valid held through three full commands: exactly three accepted.
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 2'b11;
        repeat (3 * (TOTAL + 1)) @(posedge clock);
        #1 cmd_valid = 1'b0;
        @(negedge clock);
        chk("t5_done", done, 1);
        chk("t5_count", cmd_count, 3);
        @(negedge clock);
        chk("t5_idle", cmd_ready, 1);

        // Reset in the middle of the enable pulse.
        send(2'b10);
        repeat (3) @(negedge clock);
        chk("t6_en_before", latch_enable, 1);
        reset = 1'b1;
        #1;
        chk("t6_en_dropped", latch_enable, 0);
        chk("t6_set_dropped", latch_set, 0);
        chk("t6_count", cmd_count, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            chk("t6_no_done", done, 0);
        end

        // 256 back-to-back holds: cmd_count wraps to zero.
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 2'b00;
        repeat (256 * (TOTAL + 1)) @(posedge clock);
        #1 cmd_valid = 1'b0;
        @(negedge clock);
        chk("t7_done", done, 1);
        chk("t7_wrap", cmd_count, 0);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
